// File: rtl/ov7670_capture_verilog.sv
// OV7670 pixel capture: packs camera byte pairs into RGB565 words and writes them to a frame buffer.
// Latency: 2 clk from the second byte of a pixel at the pins to the we strobe.
// Backpressure: none; the camera cannot be stalled. Pixels past the buffer end are dropped and flagged.
// Optional build macro OV7670_CAPTURE_DECIMATE_EN: 2x2 subsampling (even pixels of even lines only).
module ov7670_capture_verilog #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [9:0]        line_count,
  output logic              frame_err
);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int LINES_OUT = V_LINES / 2;
  localparam int PIX_OUT   = (H_PIXELS / 2) * (V_LINES / 2);
`else
  localparam int LINES_OUT = V_LINES;
  localparam int PIX_OUT   = H_PIXELS * V_LINES;
`endif
  localparam int PIX_W = 12;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX_OUT - 1);
  localparam logic [9:0]        LINES_TGT = 10'(LINES_OUT);
  localparam logic [PIX_W-1:0]  PIX_LINE  = PIX_W'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

  state_t           state;
  logic             vsync_r, vsync_q, href_r, href_q;
  logic [7:0]       d_r, hi;
  logic             phase;
  logic [PIX_W-1:0] pix_cnt;
  logic             line_odd;
  logic             full;
  logic             frame_bad;

  logic vs_rise, vs_fall, hr_fall, full_now, keep_pix, line_bad, frame_end_bad;

  assign vs_rise       = vsync_r & ~vsync_q;
  assign vs_fall       = ~vsync_r & vsync_q;
  assign hr_fall       = ~href_r & href_q;
  // A write at the last address this very cycle already counts as full.
  assign full_now      = full | (we & (addr == ADDR_LAST));
  assign line_bad      = (pix_cnt != PIX_LINE) | phase;
  assign frame_end_bad = frame_bad | (line_count != LINES_TGT);
`ifdef OV7670_CAPTURE_DECIMATE_EN
  assign keep_pix = ~line_odd & ~pix_cnt[0];
`else
  assign keep_pix = 1'b1;
`endif

  // Input register stage plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      vsync_q <= 1'b0;
      href_r  <= 1'b0;
      href_q  <= 1'b0;
      d_r     <= '0;
    end else begin
      vsync_r <= vsync;
      vsync_q <= vsync_r;
      href_r  <= href;
      href_q  <= href_r;
      d_r     <= d;
    end
  end

  // Frame FSM, byte packing, addressing and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      line_count <= '0;
      frame_err  <= 1'b0;
      hi         <= '0;
      phase      <= 1'b0;
      pix_cnt    <= '0;
      line_odd   <= 1'b0;
      full       <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (we) begin
        if (addr == ADDR_LAST) full <= 1'b1;
        else                   addr <= addr + 1'b1;
      end
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (vs_rise) state <= WAIT;
          end
          WAIT: begin
            if (vs_fall) begin
              addr       <= '0;
              line_count <= '0;
              phase      <= 1'b0;
              pix_cnt    <= '0;
              line_odd   <= 1'b0;
              full       <= 1'b0;
              frame_bad  <= 1'b0;
              state      <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (vs_rise) begin
              // End of frame; any partial pixel is abandoned.
              state      <= WAIT;
              phase      <= 1'b0;
              pix_cnt    <= '0;
              frame_done <= ~frame_end_bad;
              frame_err  <= frame_end_bad;
            end else if (hr_fall) begin
`ifdef OV7670_CAPTURE_DECIMATE_EN
              if (!line_odd && line_count != 10'h3ff) line_count <= line_count + 1'b1;
`else
              if (line_count != 10'h3ff) line_count <= line_count + 1'b1;
`endif
              line_odd <= ~line_odd;
              pix_cnt  <= '0;
              phase    <= 1'b0;
              if (line_bad) begin
                frame_bad <= 1'b1;
                frame_err <= 1'b1;
              end
            end else if (href_r) begin
              if (!phase) begin
                hi    <= d_r;
                phase <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (pix_cnt != {PIX_W{1'b1}}) pix_cnt <= pix_cnt + 1'b1;
                if (keep_pix) begin
                  if (full_now) begin
                    frame_bad <= 1'b1;
                    frame_err <= 1'b1;
                  end else begin
                    dout <= {hi, d_r};
                    we   <= 1'b1;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_verilog.sv
// Bench for ov7670_capture_verilog: frame-level model of expected writes and frame results,
// checked every cycle, plus literal expectations for the basic frame.
module tb_ov7670_capture_verilog;

  localparam int H  = 4;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int V    = 4;
  localparam int TGT  = V / 2;
  localparam int NPIX = (H / 2) * (V / 2);
  localparam int LIT_LAST_DOUT = 16'h1516;
`else
  localparam int V    = 2;
  localparam int TGT  = V;
  localparam int NPIX = H * V;
  localparam int LIT_LAST_DOUT = 16'h0F10;
`endif
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    d = '0;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we;
  logic          frame_done;
  logic [9:0]    line_count;
  logic          frame_err;

  ov7670_capture_verilog #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .href(href), .d(d),
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
    .line_count(line_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  logic [AW+15:0] expq[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_addr = 0;
  int last_dout = 0;

  // Frame model state
  bit         cap = 0;
  int         m_addr = 0;
  int         m_lines = 0;
  int         m_line_idx = 0;
  bit         m_err = 0;
  logic [7:0] bval = 8'd1;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then return just after the rising edge.
  task automatic cyc();
    logic [AW+15:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (we) begin
        if (expq.size() == 0) begin
          chk("we_unexpected", int'(we), 0);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", int'(addr), int'(e[AW+15:16]));
          chk("wr_dout", int'(dout), int'(e[15:0]));
        end
        wr_cnt++;
        last_addr = int'(addr);
        last_dout = int'(dout);
      end
      if (frame_done) done_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit v);
    enable = v;
    if (!v) cap = 0;
  endtask

  // Vertical sync pulse: closes the frame in progress (checked if captured) and opens the next.
  task automatic vpulse();
    int d0;
    bit ebad;
    d0 = done_cnt;
    vsync = 1'b1;
    repeat (6) cyc();
    if (cap) begin
      ebad = m_err || (m_lines != TGT);
      chk("frame_done", done_cnt - d0, ebad ? 0 : 1);
      chk("frame_err", int'(frame_err), int'(ebad));
      chk("line_count", int'(line_count), m_lines);
    end
    vsync = 1'b0;
    repeat (4) cyc();
    cap = enable;
    m_addr = 0;
    m_lines = 0;
    m_line_idx = 0;
    m_err = 0;
    bval = 8'd1;
  endtask

  // One line of nbytes; if rst_at >= 0, reset is pulsed just before that byte.
  task automatic send_line(input int nbytes, input int rst_at);
    bit keep;
    logic [7:0] hb;
    if (cap) begin
      for (int p = 0; p < nbytes / 2; p++) begin
`ifdef OV7670_CAPTURE_DECIMATE_EN
        keep = (m_line_idx % 2 == 0) && (p % 2 == 0);
`else
        keep = 1;
`endif
        hb = bval + 8'(2 * p);
        if (keep) begin
          if (m_addr < NPIX) begin
            expq.push_back({AW'(m_addr), hb, hb + 8'd1});
            m_addr++;
          end else begin
            m_err = 1;
          end
        end
      end
      if (nbytes != 2 * H) m_err = 1;
`ifdef OV7670_CAPTURE_DECIMATE_EN
      if (m_line_idx % 2 == 0) m_lines++;
`else
      m_lines++;
`endif
      m_line_idx++;
    end
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_addr", int'(addr), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_line_count", int'(line_count), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        expq.delete();
        cap = 0;
        cyc();
        rst_n = 1'b1;
      end
      d = bval + 8'(i);
      cyc();
    end
    href = 1'b0;
    d = '0;
    bval = bval + 8'(nbytes);
    repeat (4) cyc();
  endtask

  task automatic good_frame();
    for (int l = 0; l < V; l++) send_line(2 * H, -1);
  endtask

  initial begin
    int wr0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr", int'(addr), 0);
    chk("reset_we", int'(we), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_line_count", int'(line_count), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // Basic frame with bytes 0x01.. and literal pins on its results
    set_en(1);
    vpulse();
    good_frame();
    vpulse();
    chk("t1_writes", wr_cnt, NPIX);
    chk("t1_last_addr", last_addr, NPIX - 1);
    chk("t1_last_dout", last_dout, LIT_LAST_DOUT);
    chk("t1_frame_err", int'(frame_err), 0);
    chk("t1_done_count", done_cnt, 1);

    // Disabled while frames stream, enable raised mid-frame
    set_en(0);
    good_frame();
    vpulse();
    send_line(2 * H, -1);
    set_en(1);
    for (int l = 1; l < V; l++) send_line(2 * H, -1);
    chk("t2_no_writes", wr_cnt, NPIX);
    vpulse();
    wr0 = wr_cnt;
    good_frame();
    vpulse();
    chk("t2_writes", wr_cnt - wr0, NPIX);

    // Odd-length line, then a good frame that clears the error
    send_line(2 * H - 1, -1);
    for (int l = 1; l < V; l++) send_line(2 * H, -1);
    vpulse();
    chk("t3_frame_err_set", int'(frame_err), 1);
    good_frame();
    vpulse();
    chk("t3_frame_err_clear", int'(frame_err), 0);

    // One line too many: address saturates, extra pixels dropped
    for (int l = 0; l < V + 1; l++) send_line(2 * H, -1);
    chk("t4_addr_sat", int'(addr), NPIX - 1);
    vpulse();

    // Reset mid-line, recovery on the next full frame
    send_line(2 * H, -1);
    send_line(2 * H, 3);
    vpulse();
    good_frame();
    vpulse();

    chk("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
